// File: rtl/branch_predictor.sv
// branch_predictor: BTB plus saturating-counter direction predictor.
// Lookup is registered (1-cycle latency, frozen by stall); updates come from EX.
// Optional feature: define BP_GSHARE_EN to XOR a global history register into
// the counter index (gshare). Without it the counter index is the PC index.
// Ports:
//   clk, rst (async, active-low)
//   lookup_valid/lookup_pc/stall           -> fetch-side request
//   pred_valid/pred_hit/pred_taken/pred_target -> registered prediction
//   update_valid/pc/taken/target/mispredict  -> resolved branch from EX
//   mispredict_cnt                          -> saturating mispredict counter
module branch_predictor #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  input  logic        stall,
  output logic        pred_valid,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        update_mispredict,
  output logic [31:0] mispredict_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(2 ** (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(2 ** (CTR_W - 1) - 1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx_c, lk_cidx_c, u_idx_c, u_cidx_c;
  logic [TAG_W-1:0] lk_tag_c, u_tag_c;
  logic             lk_hit_c, lk_taken_c, u_hit_c, ctr_we_c;
  logic [31:0]      lk_target_c;
  logic [CTR_W-1:0] u_ctr_c, ctr_nxt_c;
  logic             unused_bits;

  // Only the index/tag slice of update_pc is meaningful.
  assign unused_bits = ^update_pc;

  assign lk_idx_c = lookup_pc[IDX_W+1:2];
  assign lk_tag_c = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx_c  = update_pc[IDX_W+1:2];
  assign u_tag_c  = update_pc[IDX_W+TAG_W+1:IDX_W+2];

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;

  // Global history: newest outcome in the LSB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_q <= '0;
    end else if (update_valid) begin
      ghr_q <= {ghr_q[IDX_W-2:0], update_taken};
    end
  end

  assign lk_cidx_c = lk_idx_c ^ ghr_q;
  assign u_cidx_c  = u_idx_c ^ ghr_q;
`else
  assign lk_cidx_c = lk_idx_c;
  assign u_cidx_c  = u_idx_c;
`endif

  // Lookup path reads pre-update state, giving read-before-write on collisions.
  always_comb begin
    lk_hit_c    = valid_q[lk_idx_c] && (tag_q[lk_idx_c] == lk_tag_c);
    lk_taken_c  = lk_hit_c && ctr_q[lk_cidx_c][CTR_W-1];
    lk_target_c = lk_taken_c ? target_q[lk_idx_c] : lookup_pc + 32'd4;
  end

  // Counter next value: saturating step on hit, weakly-taken on allocation.
  always_comb begin
    u_hit_c   = valid_q[u_idx_c] && (tag_q[u_idx_c] == u_tag_c);
    u_ctr_c   = ctr_q[u_cidx_c];
    ctr_we_c  = update_valid && (u_hit_c || update_taken);
    ctr_nxt_c = CTR_WT;
    if (u_hit_c) begin
      if (update_taken) begin
        ctr_nxt_c = (u_ctr_c == CTR_MAX) ? u_ctr_c : u_ctr_c + CTR_W'(1);
      end else begin
        ctr_nxt_c = (u_ctr_c == '0) ? u_ctr_c : u_ctr_c - CTR_W'(1);
      end
    end
  end

  // Registered prediction, held while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else if (!stall) begin
      pred_valid  <= lookup_valid;
      pred_hit    <= lk_hit_c;
      pred_taken  <= lk_taken_c;
      pred_target <= lk_target_c;
    end
  end

  // Valid bits and counters carry reset state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_WNT;
      end
    end else begin
      if (update_valid && !u_hit_c && update_taken) begin
        valid_q[u_idx_c] <= 1'b1;
      end
      if (ctr_we_c) begin
        ctr_q[u_cidx_c] <= ctr_nxt_c;
      end
    end
  end

  // Tag/target payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (update_valid && update_taken) begin
      target_q[u_idx_c] <= update_target;
      if (!u_hit_c) begin
        tag_q[u_idx_c] <= u_tag_c;
      end
    end
  end

  // Saturating mispredict performance counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mispredict_cnt <= '0;
    end else if (update_valid && update_mispredict && (mispredict_cnt != '1)) begin
      mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, number of BTB/counter entries; power of two, at least 4.
REQ-002 SHALL have parameter CTR_W, default 2, saturating-counter width; at least 2.
REQ-003 SHALL have parameter TAG_W, default 8, stored PC tag width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port lookup_valid  in  1  IF-stage fetch request.
REQ-007 SHALL have port lookup_pc  in  32  fetch PC.
REQ-008 SHALL have port stall  in  1  holds prediction outputs.
REQ-009 SHALL have port pred_valid  out  1  prediction outputs valid.
REQ-010 SHALL have port pred_hit  out  1  BTB tag hit.
REQ-011 SHALL have port pred_taken  out  1  predicted taken.
REQ-012 SHALL have port pred_target  out  32  predicted next PC.
REQ-013 SHALL have port update_valid  in  1  resolved branch from EX.
REQ-014 SHALL have port update_pc  in  32  resolved branch PC.
REQ-015 SHALL have port update_taken  in  1  actual direction.
REQ-016 SHALL have port update_target  in  32  actual taken target.
REQ-017 SHALL have port update_mispredict  in  1  EX detected a wrong prediction.
REQ-018 SHALL have port mispredict_cnt  out  32  performance counter.

Function
REQ-019 SHALL define IDX_W = log2(ENTRIES), index = pc[IDX_W+1:2], and tag = pc[IDX_W+TAG_W+1:IDX_W+2].
REQ-020 SHALL hold, per entry, valid, tag, and a 32-bit target in the BTB; the counter table SHALL hold ENTRIES counters of CTR_W bits.
REQ-021 SHALL register the prediction with 1-cycle latency: a lookup in cycle N produces outputs in cycle N+1; pred_valid SHALL equal the registered lookup_valid.
REQ-022 SHALL freeze all pred_* outputs while stall=1 and ignore lookup inputs during that time.
REQ-023 SHALL set pred_hit = valid and tag match.
REQ-024 SHALL set pred_taken = pred_hit and counter MSB=1.
REQ-025 SHALL set pred_target = BTB target when pred_taken=1, else lookup_pc+4 (modulo 2^32).
REQ-026 SHALL, on an update hit, increment the counter on taken and decrement it on not-taken, saturating at all-ones and at 0; the BTB target SHALL be written only when taken.
REQ-027 SHALL, on an update miss with taken=1, allocate the entry (overwriting any victim): set valid, write tag and target, and set the counter to weakly-taken 2^(CTR_W-1).
REQ-028 SHALL leave BTB and counter unchanged on an update miss with taken=0.
REQ-029 SHALL resolve a same-cycle lookup and update to the same index as read-before-write: the lookup sees the old state.
REQ-030 SHALL increment mispredict_cnt when update_valid and update_mispredict are both 1, saturating at 0xFFFFFFFF.
REQ-031 SHALL ignore update_mispredict when update_valid=0.

Reset
REQ-032 SHALL, while rst=0, immediately clear all valid bits, set all counters to weakly-not-taken 2^(CTR_W-1)-1, clear GHR and mispredict_cnt, and drive every pred_* output to 0.
REQ-033 SHALL, when reset is asserted mid-operation, discard any in-flight lookup; the first valid prediction SHALL appear one cycle after the first lookup following reset release.

Configuration
REQ-034 SHALL compile gshare indexing in when macro BP_GSHARE_EN is defined: an IDX_W-bit global history register shifts in update_taken on each update_valid, and the counter index is pc index XOR GHR; BTB indexing is unchanged.
REQ-035 SHALL, without BP_GSHARE_EN, have no GHR, and the counter index SHALL equal the pc index (bimodal).

Verification
REQ-036 SHALL check: after reset, lookup 0x00400000 -> next cycle pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0x00400004.
REQ-037 SHALL check: update pc=0x00400010 taken target=0x00400100, then lookup 0x00400010 -> pred_hit=1, pred_taken=1, pred_target=0x00400100.
REQ-038 SHALL check: 3 not-taken updates on that entry with CTR_W=2 -> counter 0, pred_taken=0, pred_target=0x00400014; 5 further not-taken updates keep the counter at 0.
REQ-039 SHALL check: same-cycle lookup and allocating update on 0x00400020 -> that lookup misses, and the next lookup hits.
REQ-040 SHALL check: stall=1 for 3 cycles with changing lookup_pc -> pred_* outputs stay constant.
REQ-041 SHALL check: 5 updates with mispredict=1 plus 2 with update_valid=0 and mispredict=1 -> mispredict_cnt=5; asserting rst mid-run -> mispredict_cnt=0 and all lookups miss.
